// File: rtl/pc_gen_pkg.sv
// Shared defaults, types and helpers for the fetch-stage PC generator.
package pc_gen_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int unsigned INST_BYTES_DEF   = 4;
  localparam int unsigned EPOCH_W_DEF      = 2;

  typedef logic [XLEN_DEF-1:0]    pc_t;
  typedef logic [EPOCH_W_DEF-1:0] epoch_t;

  // IDLE only exists between reset release and the first edge.
  typedef enum logic [1:0] {
    FS_IDLE,
    FS_RUN,
    FS_PEND
  } fetch_state_e;

  function automatic pc_t align_pc(input pc_t pc, input int unsigned align_w);
    pc_t mask;
    mask = '1;
    mask = mask << align_w;
    return pc & mask;
  endfunction

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch request channel from the PC generator to instruction memory.
interface pc_gen_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned EPOCH_W = 2
) ();

  logic               fetch_valid_o;
  logic               fetch_ready_i;
  logic [XLEN-1:0]    fetch_pc_o;
  logic [EPOCH_W-1:0] fetch_epoch_o;

  modport master (
    output fetch_valid_o,
    input  fetch_ready_i,
    output fetch_pc_o,
    output fetch_epoch_o
  );

  modport slave (
    input  fetch_valid_o,
    output fetch_ready_i,
    input  fetch_pc_o,
    input  fetch_epoch_o
  );

endinterface

// File: rtl/pc_gen_unit_redir_arbiter.sv
// Fixed-priority redirect select (index 0 wins) with target alignment.
module redir_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REDIR = 2,
  parameter int unsigned ALIGN_W   = 2
) (
  input  logic [NUM_REDIR-1:0]      valid,
  input  logic [NUM_REDIR*XLEN-1:0] pc,
  output logic                      any_valid,
  output logic [XLEN-1:0]           tgt,
  output logic                      misaligned
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_W) - 64'd1);

  logic [XLEN-1:0] raw;

  always_comb begin
    any_valid = 1'b0;
    raw       = '0;
    for (int unsigned k = 0; k < NUM_REDIR; k++) begin
      if (valid[k] && !any_valid) begin
        any_valid = 1'b1;
        raw       = pc[k*XLEN +: XLEN];
      end
    end
  end

  assign tgt        = raw & ~LOW_MASK;
  assign misaligned = |(raw & LOW_MASK);

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: sequential advance, prioritised redirects, held-redirect buffer, epoch tags.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned     NUM_REDIR    = 2,
  parameter int unsigned     INST_BYTES   = INST_BYTES_DEF,
  parameter int unsigned     EPOCH_W      = EPOCH_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall_i,
  input  logic [NUM_REDIR-1:0]      redir_valid_i,
  input  logic [NUM_REDIR*XLEN-1:0] redir_pc_i,
  pc_gen_unit_if.master             fetch,
  output logic                      pending_o,
  output logic                      redir_misaligned_o
);

  localparam int unsigned ALIGN_W = $clog2(INST_BYTES);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pend_pc_q, pend_pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               mis_q;

  logic            any_valid, misaligned, valid, xfer, hold;
  logic [XLEN-1:0] tgt;

  redir_arbiter #(
    .XLEN      (XLEN),
    .NUM_REDIR (NUM_REDIR),
    .ALIGN_W   (ALIGN_W)
  ) u_arb (
    .valid      (redir_valid_i),
    .pc         (redir_pc_i),
    .any_valid  (any_valid),
    .tgt        (tgt),
    .misaligned (misaligned)
  );

  assign valid = (state_q != FS_IDLE);
  assign xfer  = valid & fetch.fetch_ready_i;
  assign hold  = valid & ~fetch.fetch_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FS_IDLE;
      pc_q      <= RESET_VECTOR;
      pend_pc_q <= '0;
      epoch_q   <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      epoch_q   <= epoch_d;
      mis_q     <= any_valid & misaligned;
    end
  end

  // PEND means the held request is stale and pend_pc_q replaces it once it transfers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    epoch_d   = epoch_q;
    if (any_valid && !hold) begin
      pc_d    = tgt;
      epoch_d = epoch_q + EPOCH_W'(1);
      state_d = FS_RUN;
    end else if (any_valid) begin
      pend_pc_d = tgt;
      state_d   = FS_PEND;
    end else if (state_q == FS_PEND && xfer) begin
      pc_d    = pend_pc_q;
      epoch_d = epoch_q + EPOCH_W'(1);
      state_d = FS_RUN;
    end else begin
      if (xfer && !stall_i) pc_d = pc_q + XLEN'(INST_BYTES);
      if (state_q == FS_IDLE) state_d = FS_RUN;
    end
  end

  assign fetch.fetch_valid_o = valid;
  assign fetch.fetch_pc_o    = pc_q;
  assign fetch.fetch_epoch_o = epoch_q;
  assign pending_o           = (state_q == FS_PEND);
  assign redir_misaligned_o  = mis_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed scoreboard bench for pc_gen_unit (XLEN=32, 2 sources, 4-byte instructions, 2-bit epoch).
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic [1:0]  redir_valid_i;
  logic [63:0] redir_pc_i;
  logic        pending_o;
  logic        redir_misaligned_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic        pend;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  pc_gen_unit_if #(.XLEN(32), .EPOCH_W(2)) fif ();

  pc_gen_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .NUM_REDIR    (2),
    .INST_BYTES   (4),
    .EPOCH_W      (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall_i            (stall_i),
    .redir_valid_i      (redir_valid_i),
    .redir_pc_i         (redir_pc_i),
    .fetch              (fif),
    .pending_o          (pending_o),
    .redir_misaligned_o (redir_misaligned_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(fif.fetch_valid_o), 32'd0);
    chk({tag, "_pc"},    fif.fetch_pc_o, 32'h0);
    chk({tag, "_epoch"}, 32'(fif.fetch_epoch_o), 32'd0);
    chk({tag, "_pend"},  32'(pending_o), 32'd0);
    chk({tag, "_mis"},   32'(redir_misaligned_o), 32'd0);
  endtask

  // Drive one cycle of inputs, queue the post-edge expectation, then compare it.
  task automatic cyc(input string tag, input logic st, input logic [1:0] rv,
                     input logic [31:0] r0, input logic [31:0] r1, input logic rdy,
                     input logic [31:0] epc, input logic [1:0] eep,
                     input logic epend, input logic emis);
    exp_t e;
    stall_i           = st;
    redir_valid_i     = rv;
    redir_pc_i        = {r1, r0};
    fif.fetch_ready_i = rdy;
    e.v = 1'b1; e.pc = epc; e.ep = eep; e.pend = epend; e.mis = emis;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty got=0 exp=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(fif.fetch_valid_o), 32'(e.v));
      chk({tag, "_pc"},    fif.fetch_pc_o, e.pc);
      chk({tag, "_epoch"}, 32'(fif.fetch_epoch_o), 32'(e.ep));
      chk({tag, "_pend"},  32'(pending_o), 32'(e.pend));
      chk({tag, "_mis"},   32'(redir_misaligned_o), 32'(e.mis));
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    stall_i           = 1'b0;
    redir_valid_i     = 2'b00;
    redir_pc_i        = '0;
    fif.fetch_ready_i = 1'b1;
    #12;
    chk_reset("reset");
    rst_n = 1'b1;

    //   tag      st  rv     r0            r1            rdy  pc            ep    pend  mis
    cyc("seq0",   0, 2'b00, 32'h0,        32'h0,        1,   32'h0,        2'd0, 0,    0);
    cyc("seq1",   0, 2'b00, 32'h0,        32'h0,        1,   32'h4,        2'd0, 0,    0);
    cyc("seq2",   0, 2'b00, 32'h0,        32'h0,        1,   32'h8,        2'd0, 0,    0);
    cyc("stall1", 1, 2'b00, 32'h0,        32'h0,        1,   32'h8,        2'd0, 0,    0);
    cyc("stall2", 1, 2'b00, 32'h0,        32'h0,        1,   32'h8,        2'd0, 0,    0);
    cyc("stall3", 1, 2'b00, 32'h0,        32'h0,        1,   32'h8,        2'd0, 0,    0);
    cyc("resume", 0, 2'b00, 32'h0,        32'h0,        1,   32'hC,        2'd0, 0,    0);
    cyc("seq4",   0, 2'b00, 32'h0,        32'h0,        1,   32'h10,       2'd0, 0,    0);
    cyc("hold1",  0, 2'b00, 32'h0,        32'h0,        0,   32'h10,       2'd0, 0,    0);
    cyc("hold2",  0, 2'b01, 32'h300,      32'h0,        0,   32'h10,       2'd0, 1,    0);
    cyc("hold3",  0, 2'b00, 32'h0,        32'h0,        0,   32'h10,       2'd0, 1,    0);
    cyc("hold4",  0, 2'b00, 32'h0,        32'h0,        0,   32'h10,       2'd0, 1,    0);
    cyc("apply",  0, 2'b00, 32'h0,        32'h0,        1,   32'h300,      2'd1, 0,    0);
    cyc("prio",   1, 2'b11, 32'h100,      32'h200,      1,   32'h100,      2'd2, 0,    0);
    cyc("misal",  0, 2'b10, 32'h0,        32'h102,      1,   32'h100,      2'd3, 0,    1);
    cyc("misoff", 0, 2'b00, 32'h0,        32'h0,        1,   32'h104,      2'd3, 0,    0);
    cyc("epwrap", 0, 2'b01, 32'hFFFF_FFFC, 32'h0,       1,   32'hFFFF_FFFC, 2'd0, 0,   0);
    cyc("pcwrap", 0, 2'b00, 32'h0,        32'h0,        1,   32'h0,        2'd0, 0,    0);
    cyc("bhold",  0, 2'b00, 32'h0,        32'h0,        0,   32'h0,        2'd0, 0,    0);
    cyc("bmis",   0, 2'b01, 32'h503,      32'h0,        0,   32'h0,        2'd0, 1,    1);
    cyc("bover",  0, 2'b10, 32'h0,        32'h600,      0,   32'h0,        2'd0, 1,    0);
    cyc("bstall", 1, 2'b00, 32'h0,        32'h0,        1,   32'h600,      2'd1, 0,    0);
    cyc("replay", 1, 2'b00, 32'h0,        32'h0,        1,   32'h600,      2'd1, 0,    0);
    cyc("pend",   0, 2'b01, 32'h700,      32'h0,        0,   32'h600,      2'd1, 1,    0);

    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    #2;
    rst_n = 1'b1;
    cyc("post0",  0, 2'b00, 32'h0,        32'h0,        1,   32'h0,        2'd0, 0,    0);
    cyc("post1",  0, 2'b00, 32'h0,        32'h0,        1,   32'h4,        2'd0, 0,    0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
